ws2812b_frame_scheduler: RTL and testbench
==========================================

Name: ws2812b_frame_scheduler

Overview:
- Sequences whole frames of pixels into the AXI-Stream WS2812B serializer (24-bit GRB words).
- Holds a local pixel buffer with a host write port and applies global brightness scaling.
- Streams NUM_LEDS words per frame, then enforces the WS2812B latch/reset gap.
- Starts frames on a periodic refresh tick or a manual start pulse, replacing ad-hoc delay counters in top-level designs.

Parameters:
- NUM_LEDS, 8: pixels per frame (1..256).
- LATCH_CYCLES, 14400: idle cycles after the last accepted word (≥280 µs at 48 MHz).
- REFRESH_CYCLES, 48000000: auto-trigger period in sysclk cycles; 0 disables auto refresh.
- ADDR_W, 8: pixel address width; must satisfy 2^ADDR_W ≥ NUM_LEDS.

Ports:
- sysclk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  pixel buffer write strobe.
- wr_addr  in  ADDR_W  pixel index; writes with wr_addr ≥ NUM_LEDS are ignored.
- wr_data  in  24  GRB pixel value.
- brightness  in  8  global scale; sampled at frame start.
- start  in  1  one-cycle frame request.
- m_axis_tdata  out  24  scaled pixel to the serializer.
- m_axis_tvalid  out  1  word valid.
- m_axis_tready  in  1  serializer ready.
- m_axis_tlast  out  1  high with the last pixel of a frame.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when LATCH completes.

Behaviour:
- Reset:
  - State IDLE; idx, latch counter and refresh counter = 0; pending = 0.
  - Buffer cleared to 24'h000000; brightness latch = 0.
  - All outputs 0.
- Refresh counter:
  - Free-running 0..REFRESH_CYCLES-1; tick = 1 in the cycle the counter equals REFRESH_CYCLES-1, then it wraps to 0.
  - No tick when REFRESH_CYCLES = 0.
- Trigger = start | tick.
  - In IDLE, a trigger starts a frame.
  - In any other state, it sets pending. Multiple triggers collapse into one pending.
- States:
  - IDLE: on trigger or pending → FETCH. idx = 0, brightness latched, pending cleared.
  - FETCH (1 cycle): read buffer[idx]. Load m_axis_tdata with the scaled value; tlast = (idx == NUM_LEDS-1) → SEND.
  - SEND: tvalid = 1. tdata and tlast are held stable until tvalid & tready.
    - On handshake with idx < NUM_LEDS-1: idx++ → FETCH; tvalid deasserts for that cycle.
    - On handshake of the last word: → LATCH, counter = 0.
  - LATCH: tvalid = 0; counter increments each cycle. On reaching LATCH_CYCLES-1: frame_done = 1 for that cycle → IDLE.
- Latency:
  - start in IDLE at cycle t → tvalid first high at t+2.
  - Pending from a mid-frame trigger: next FETCH one cycle after LATCH exits via IDLE.
- Scaling, per 8-bit channel: out = (c × (brightness+1)) >> 8, 16-bit intermediate.
  - brightness 255 passes through exactly; brightness 0 yields 0.
- Buffer writes are accepted in every state.
  - A write to the FETCH-cycle address in the same cycle: the new data is used (write-first).
  - A write to an already-sent index affects the next frame only.
- Reset mid-frame: everything returns to the reset state on the next edge; tvalid drops with no tlast emitted.
- tready high outside SEND has no effect.

Decomposition:
- Shared package ws2812b_pkg:
  - PIXEL_W = 24, CHAN_W = 8;
  - state encoding (IDLE, FETCH, SEND, LATCH);
  - default timing constants for 48 MHz (LATCH_CYCLES_48M, REFRESH_1HZ_48M).
- One sub-module: ws2812b_brightness_scale, a combinational 24-bit three-channel scaler instantiated in the FETCH path.

Test Plan:
- NUM_LEDS=4, LATCH_CYCLES=16, REFRESH_CYCLES=0, brightness=255; write 0x010203, 0x404040, 0xFF0000, 0x00FF00; start; tready=1 → four words in order, tlast only on 0x00FF00, first tvalid 2 cycles after start, frame_done 16 cycles after the last handshake, busy=0 afterwards.
- Same buffer, brightness=0x7F → 0x010203 gives 0x000101, 0x404040 gives 0x202020, 0xFF0000 gives 0x7F0000, 0x00FF00 gives 0x007F00.
- tready held low 10 cycles on word 2 → tvalid stays high, tdata/tlast stable, no word skipped or duplicated.
- start pulsed during SEND and again during LATCH → exactly one extra frame starts after frame_done; no third frame.
- REFRESH_CYCLES=100, LATCH_CYCLES=16, no start → a frame begins every 100 cycles; write to wr_addr=4 (≥NUM_LEDS) → no buffer change.
- reset asserted while SEND on word 1 → next cycle tvalid=0, busy=0; subsequent start streams buffer contents all 0x000000.

Source files
------------

// File: rtl/ws2812b_pkg.sv
// Shared types and constants for the WS2812B frame scheduler and its pixel scaler.
// Timing defaults assume a 48 MHz system clock.
package ws2812b_pkg;

    localparam int unsigned PIXEL_W = 24;
    localparam int unsigned CHAN_W  = 8;

    // 300 us latch gap and a 1 Hz refresh period at 48 MHz
    localparam int unsigned LATCH_CYCLES_48M = 14400;
    localparam int unsigned REFRESH_1HZ_48M  = 48000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        LATCH = 2'd3
    } sched_state_t;

endpackage

// File: rtl/ws2812b_brightness_scale.sv
// Combinational three-channel brightness scaler: out = (c * (brightness + 1)) >> 8.
// brightness 255 is an exact pass-through and brightness 0 blanks the pixel.
module ws2812b_brightness_scale
    import ws2812b_pkg::*;
(
    input  logic [PIXEL_W-1:0] pixel,
    input  logic [CHAN_W-1:0]  brightness,
    output logic [PIXEL_W-1:0] scaled
);

    localparam int unsigned NUM_CHAN = PIXEL_W / CHAN_W;

    logic [2*CHAN_W-1:0] gain;
    assign gain = {{CHAN_W{1'b0}}, brightness} + (2*CHAN_W)'(1);

    generate
        for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
            logic [2*CHAN_W-1:0] product;
            assign product = {{CHAN_W{1'b0}}, pixel[gi*CHAN_W +: CHAN_W]} * gain;
            assign scaled[gi*CHAN_W +: CHAN_W] = CHAN_W'(product >> CHAN_W);
        end
    endgenerate

endmodule

// File: rtl/ws2812b_frame_scheduler.sv
// Streams a locally buffered, brightness-scaled frame of GRB pixels to an AXI-Stream
// WS2812B serializer, then holds the line idle for the latch gap before the next frame.
module ws2812b_frame_scheduler
    import ws2812b_pkg::*;
#(
    parameter int unsigned NUM_LEDS       = 8,
    parameter int unsigned LATCH_CYCLES   = LATCH_CYCLES_48M,
    parameter int unsigned REFRESH_CYCLES = REFRESH_1HZ_48M,
    parameter int unsigned ADDR_W         = 8
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [PIXEL_W-1:0] wr_data,
    input  logic [CHAN_W-1:0]  brightness,
    input  logic               start,
    output logic [PIXEL_W-1:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic               busy,
    output logic               frame_done
);

    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_LEDS - 1);
    localparam logic [31:0]       LATCH_LAST = 32'(LATCH_CYCLES - 1);

    sched_state_t       state_reg, state_next;
    logic [ADDR_W-1:0]  idx_reg, idx_next;
    logic [31:0]        latch_reg, latch_next;
    logic               pending_reg, pending_next;
    logic [CHAN_W-1:0]  bright_reg, bright_next;
    logic [PIXEL_W-1:0] tdata_reg, tdata_next;
    logic               tlast_reg, tlast_next;

    logic               tick;
    logic               trigger;
    logic [PIXEL_W-1:0] pixel_mem [NUM_LEDS];
    logic [PIXEL_W-1:0] rd_pixel;
    logic [PIXEL_W-1:0] fetch_pixel;
    logic [PIXEL_W-1:0] scaled_pixel;

    // Refresh tick generator; absent entirely when auto refresh is disabled
    generate
        if (REFRESH_CYCLES > 0) begin : g_refresh
            localparam logic [31:0] REFRESH_LAST = 32'(REFRESH_CYCLES - 1);
            logic [31:0] refresh_reg;

            always_ff @(posedge sysclk) begin
                if (reset) begin
                    refresh_reg <= '0;
                end else if (refresh_reg == REFRESH_LAST) begin
                    refresh_reg <= '0;
                end else begin
                    refresh_reg <= refresh_reg + 32'd1;
                end
            end

            assign tick = (refresh_reg == REFRESH_LAST);
        end else begin : g_no_refresh
            assign tick = 1'b0;
        end
    endgenerate

    assign trigger = start | tick;

    // Pixel buffer: addresses at or beyond NUM_LEDS never match an entry
    always_ff @(posedge sysclk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                pixel_mem[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (wr_addr == ADDR_W'(i)) begin
                    pixel_mem[i] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        rd_pixel = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (idx_reg == ADDR_W'(i)) begin
                rd_pixel = pixel_mem[i];
            end
        end
    end

    // Write-first: a same-cycle host write to the fetched index wins
    assign fetch_pixel = (wr_en && (wr_addr == idx_reg)) ? wr_data : rd_pixel;

    ws2812b_brightness_scale u_scale (
        .pixel      (fetch_pixel),
        .brightness (bright_reg),
        .scaled     (scaled_pixel)
    );

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            latch_reg   <= '0;
            pending_reg <= 1'b0;
            bright_reg  <= '0;
            tdata_reg   <= '0;
            tlast_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            latch_reg   <= latch_next;
            pending_reg <= pending_next;
            bright_reg  <= bright_next;
            tdata_reg   <= tdata_next;
            tlast_reg   <= tlast_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        latch_next   = latch_reg;
        pending_next = pending_reg | trigger;
        bright_next  = bright_reg;
        tdata_next   = tdata_reg;
        tlast_next   = tlast_reg;
        frame_done   = 1'b0;

        unique case (state_reg)
            IDLE: begin
                pending_next = 1'b0;
                if (trigger || pending_reg) begin
                    state_next  = FETCH;
                    idx_next    = '0;
                    bright_next = brightness;
                end
            end
            FETCH: begin
                tdata_next = scaled_pixel;
                tlast_next = (idx_reg == LAST_IDX);
                state_next = SEND;
            end
            SEND: begin
                if (m_axis_tready) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = LATCH;
                        latch_next = '0;
                    end else begin
                        state_next = FETCH;
                        idx_next   = idx_reg + ADDR_W'(1);
                    end
                end
            end
            LATCH: begin
                if (latch_reg == LATCH_LAST) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end else begin
                    latch_next = latch_reg + 32'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tvalid = (state_reg == SEND);
    assign m_axis_tlast  = tlast_reg && (state_reg == SEND);
    assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_ws2812b_frame_scheduler.sv
// Directed bench for the WS2812B frame scheduler: scoreboard of expected AXI-Stream words,
// plus a second instance with auto refresh enabled to check the refresh period.
module tb_ws2812b_frame_scheduler;

    logic sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Instance A: manual start only
    logic        reset_a, wr_en_a, start_a, tready_a;
    logic [7:0]  wr_addr_a, brightness_a;
    logic [23:0] wr_data_a, tdata_a;
    logic        tvalid_a, tlast_a, busy_a, frame_done_a;

    // Instance B: refresh every 100 cycles
    logic        reset_b, wr_en_b, start_b, tready_b;
    logic [7:0]  wr_addr_b, brightness_b;
    logic [23:0] wr_data_b, tdata_b;
    logic        tvalid_b, tlast_b, busy_b, frame_done_b;

    ws2812b_frame_scheduler #(
        .NUM_LEDS(4), .LATCH_CYCLES(16), .REFRESH_CYCLES(0), .ADDR_W(8)
    ) dut_a (
        .sysclk(sysclk), .reset(reset_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .brightness(brightness_a), .start(start_a),
        .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a), .m_axis_tready(tready_a),
        .m_axis_tlast(tlast_a), .busy(busy_a), .frame_done(frame_done_a)
    );

    ws2812b_frame_scheduler #(
        .NUM_LEDS(4), .LATCH_CYCLES(16), .REFRESH_CYCLES(100), .ADDR_W(8)
    ) dut_b (
        .sysclk(sysclk), .reset(reset_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .brightness(brightness_b), .start(start_b),
        .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(tready_b),
        .m_axis_tlast(tlast_b), .busy(busy_b), .frame_done(frame_done_b)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int hs_count = 0;
    int last_hs_cyc = 0;
    int done_cyc = 0;
    int rise_q[$];
    logic [24:0] exp_q[$];
    logic [24:0] sb_word;
    logic busy_b_prev = 1'b0;
    logic [23:0] pix [4];

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [23:0] scale_px(input logic [23:0] p, input logic [7:0] b);
        logic [23:0] r;
        for (int c = 0; c < 3; c++) begin
            int unsigned v;
            v = (int'(p[c*8 +: 8]) * (int'(b) + 1)) / 256;
            r[c*8 +: 8] = 8'(v);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic pulse_start();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic push_frame(input logic [7:0] b);
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), scale_px(pix[i], b)});
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!frame_done_a && n < 400) begin
            tick();
            n++;
        end
        check(tag, {31'b0, frame_done_a}, 32'd1);
        done_cyc = cyc;
    endtask

    // Scoreboard for instance A: one line per accepted word
    always @(negedge sysclk) begin
        if (tvalid_a && tready_a) begin
            hs_count++;
            check("scoreboard_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                sb_word = exp_q.pop_front();
                $display("word %0d: tdata=%06h tlast=%0b expected %06h/%0b",
                         hs_count, tdata_a, tlast_a, sb_word[23:0], sb_word[24]);
                check("word", {7'b0, tlast_a, tdata_a}, {7'b0, sb_word});
            end
            if (tlast_a) last_hs_cyc = cyc;
        end
    end

    // Instance B: buffer stays zero (out-of-range write ignored); log frame starts
    always @(negedge sysclk) begin
        if (tvalid_b && tready_b) check("refresh_word_zero", {8'b0, tdata_b}, 32'd0);
        if (busy_b && !busy_b_prev) rise_q.push_back(cyc);
        busy_b_prev = busy_b;
    end

    initial begin
        logic [23:0] cap_data;
        logic        cap_last;
        logic        stable;
        logic        busy_seen;
        int          n;
        int          base;

        pix[0] = 24'h010203; pix[1] = 24'h404040; pix[2] = 24'hFF0000; pix[3] = 24'h00FF00;
        reset_a = 1'b1; wr_en_a = 1'b0; wr_addr_a = '0; wr_data_a = '0; start_a = 1'b0;
        tready_a = 1'b1; brightness_a = 8'hFF;
        reset_b = 1'b1; wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0; start_b = 1'b0;
        tready_b = 1'b1; brightness_b = 8'hFF;
        repeat (3) tick();

        check("rst_tvalid", {31'b0, tvalid_a}, 32'd0);
        check("rst_tlast", {31'b0, tlast_a}, 32'd0);
        check("rst_tdata", {8'b0, tdata_a}, 32'd0);
        check("rst_busy", {31'b0, busy_a}, 32'd0);
        check("rst_frame_done", {31'b0, frame_done_a}, 32'd0);
        reset_a = 1'b0;
        reset_b = 1'b0;

        // Out-of-range write to B must not alias into its buffer
        wr_en_b = 1'b1; wr_addr_b = 8'd4; wr_data_b = 24'hABCDEF;
        for (int i = 0; i < 4; i++) begin
            wr_en_a = 1'b1; wr_addr_a = 8'(i); wr_data_a = pix[i];
            tick();
            wr_en_b = 1'b0;
        end
        wr_en_a = 1'b0;

        // Frame 1: full brightness, latency and latch gap
        push_frame(8'hFF);
        pulse_start();
        check("lat_t1_tvalid", {31'b0, tvalid_a}, 32'd0);
        check("lat_t1_busy", {31'b0, busy_a}, 32'd1);
        tick();
        check("lat_t2_tvalid", {31'b0, tvalid_a}, 32'd1);
        wait_done("frame1_done");
        check("latch_gap", 32'(done_cyc - last_hs_cyc), 32'd16);
        tick();
        check("done_one_cycle", {31'b0, frame_done_a}, 32'd0);
        check("idle_busy", {31'b0, busy_a}, 32'd0);
        check("frame1_sb_empty", 32'(exp_q.size()), 32'd0);

        // Frame 2: brightness 0x7F with hand-computed results
        brightness_a = 8'h7F;
        exp_q.push_back({1'b0, 24'h000101});
        exp_q.push_back({1'b0, 24'h202020});
        exp_q.push_back({1'b0, 24'h7F0000});
        exp_q.push_back({1'b1, 24'h007F00});
        pulse_start();
        wait_done("frame2_done");
        tick();
        check("frame2_sb_empty", 32'(exp_q.size()), 32'd0);

        // Frame 3: back-pressure on word 2
        brightness_a = 8'hFF;
        push_frame(8'hFF);
        base = hs_count;
        pulse_start();
        n = 0;
        while (!(hs_count == base + 1 && tvalid_a) && n < 50) begin
            tick();
            n++;
        end
        check("stall_reached_word2", 32'(hs_count - base), 32'd1);
        tready_a = 1'b0;
        cap_data = tdata_a;
        cap_last = tlast_a;
        stable = 1'b1;
        repeat (10) begin
            tick();
            stable &= tvalid_a && (tdata_a == cap_data) && (tlast_a == cap_last);
        end
        check("stall_stable", {31'b0, stable}, 32'd1);
        check("stall_word2_data", {8'b0, cap_data}, {8'b0, scale_px(pix[1], 8'hFF)});
        tready_a = 1'b1;
        wait_done("frame3_done");
        tick();
        check("frame3_sb_empty", 32'(exp_q.size()), 32'd0);

        // Triggers during SEND and LATCH collapse into a single extra frame
        push_frame(8'hFF);
        push_frame(8'hFF);
        pulse_start();
        tick();
        check("pend_in_send", {31'b0, tvalid_a}, 32'd1);
        pulse_start();
        n = 0;
        while (!(tvalid_a && tlast_a) && n < 50) begin
            tick();
            n++;
        end
        tick();
        check("pend_in_latch", {30'b0, busy_a, tvalid_a}, 32'd2);
        pulse_start();
        wait_done("pend_f1_done");
        tick();
        check("pend_idle_gap", {31'b0, busy_a}, 32'd0);
        tick();
        check("pend_fetch", {31'b0, busy_a}, 32'd1);
        tick();
        check("pend_send", {31'b0, tvalid_a}, 32'd1);
        wait_done("pend_f2_done");
        busy_seen = 1'b0;
        repeat (40) begin
            tick();
            busy_seen |= busy_a;
        end
        check("no_third_frame", {31'b0, busy_seen}, 32'd0);
        check("pend_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset while the first word is waiting in SEND
        tready_a = 1'b0;
        pulse_start();
        tick();
        check("rst_mid_pre_tvalid", {31'b0, tvalid_a}, 32'd1);
        reset_a = 1'b1;
        tick();
        check("rst_mid_tvalid", {31'b0, tvalid_a}, 32'd0);
        check("rst_mid_busy", {31'b0, busy_a}, 32'd0);
        check("rst_mid_tlast", {31'b0, tlast_a}, 32'd0);
        reset_a = 1'b0;
        tready_a = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), 24'h000000});
        pulse_start();
        wait_done("post_rst_done");
        tick();
        check("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);

        repeat (150) tick();
        check("refresh_frame_count", {31'b0, rise_q.size() >= 3}, 32'd1);
        if (rise_q.size() >= 3) begin
            check("refresh_period_1", 32'(rise_q[1] - rise_q[0]), 32'd100);
            check("refresh_period_2", 32'(rise_q[2] - rise_q[1]), 32'd100);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
